// File: rtl/rr_arbiter4_32bit_pkg.sv
// rr_arbiter4_32bit_pkg: shared widths, requester count, FSM states and grant decode.
package rr_arbiter4_32bit_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int NUM_REQ = 4;
  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_t;
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter4_32bit_if.sv
// rr_arbiter4_32bit_if: four requester words in, one registered word out with valid/ready.
interface rr_arbiter4_32bit_if import rr_arbiter4_32bit_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] ack;
  logic [WIDTH-1:0] in1, in2, in3, in4, out;
  logic out_valid, out_ready;
  logic [1:0] sel;
  modport master (output req, in1, in2, in3, in4, out_ready, input ack, out, out_valid, sel);
  modport slave (input req, in1, in2, in3, in4, out_ready, output ack, out, out_valid, sel);
endinterface

// File: rtl/rr_arbiter4_32bit_mux.sv
// mux4to1_32bit: 4:1 data word select.
module mux4to1_32bit #(parameter int WIDTH = 32) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel[1] ? (i_sel[0] ? i_d3 : i_d2) : (i_sel[0] ? i_d1 : i_d0);
endmodule

// File: rtl/rr_arbiter4_32bit_pick.sv
// rr_pick4: first set request searching last+1, last+2, last+3, last (mod 4).
module rr_pick4 import rr_arbiter4_32bit_pkg::*; (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_last,
  output logic [1:0]         o_gnt_idx,
  output logic               o_any
);
  always_comb begin
    o_gnt_idx = i_last;
    for (int k = NUM_REQ; k >= 1; k--)
      if (i_req[i_last + 2'(k)]) o_gnt_idx = i_last + 2'(k);
  end
  assign o_any = |i_req;
endmodule

// File: rtl/rr_arbiter4_32bit.sv
// rr_arbiter4_32bit: round-robin 4:1 arbiter with one-entry registered output.
// Define ARB_BURST_EN to let a requester keep the grant for up to BURST_LEN loads.
module rr_arbiter4_32bit import rr_arbiter4_32bit_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
`ifdef ARB_BURST_EN
  , parameter int BURST_LEN = 4
`endif
) (
  input logic clk,
  input logic reset,
  rr_arbiter4_32bit_if.slave bus
);
  state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_out, w_mux;
  logic [1:0] r_sel, r_last, w_pick, w_gnt;
  logic w_any, w_load;
  rr_pick4 u_pick (.i_req(bus.req), .i_last(r_last), .o_gnt_idx(w_pick), .o_any(w_any));
  mux4to1_32bit #(.WIDTH(WIDTH)) u_mux (
    .i_sel(w_gnt), .i_d0(bus.in1), .i_d1(bus.in2), .i_d2(bus.in3), .i_d3(bus.in4), .o_y(w_mux)
  );
  // Reset gating keeps ack low in the cycle a transfer is aborted.
  assign w_load = w_any && (r_state == IDLE || bus.out_ready) && !reset;
`ifdef ARB_BURST_EN
  localparam int CW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  logic [CW-1:0] r_burst_cnt;
  logic w_burst;
  assign w_burst = bus.req[r_last] && int'(r_burst_cnt) < BURST_LEN - 1;
  assign w_gnt = w_burst ? r_last : w_pick;
  always_ff @(posedge clk)
    if (reset) r_burst_cnt <= '0;
    else if (w_load) r_burst_cnt <= w_burst ? r_burst_cnt + 1'b1 : '0;
`else
  assign w_gnt = w_pick;
`endif
  always_comb w_state_nx = w_load ? FULL : (bus.out_ready ? IDLE : r_state);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_out <= '0;
      r_sel <= 2'd0;
      r_last <= 2'd3;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_out <= w_mux;
        r_sel <= w_gnt;
        r_last <= w_gnt;
      end
    end
  end
  assign bus.ack = w_load ? onehot4(w_gnt) : '0;
  assign bus.out = r_out;
  assign bus.out_valid = r_state == FULL;
  assign bus.sel = r_sel;
endmodule

// File: tb/tb_rr_arbiter4_32bit.sv
// tb_rr_arbiter4_32bit: directed checks of grant order, stall, fairness, reset and burst.
module tb_rr_arbiter4_32bit;
  logic clk = 0, reset = 1;
  int n_tests = 0, n_fail = 0;
  logic [31:0] data [4] = '{32'hAFAFAFAF, 32'h0767A631, 32'hCDCDCDCD, 32'hFDFDEBEB};
`ifdef ARB_BURST_EN
  logic [1:0] exp_b [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
`else
  logic [1:0] exp_b [9] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
`endif
  logic [1:0] exp_alt [4] = '{2'd3, 2'd0, 2'd3, 2'd0};
  rr_arbiter4_32bit_if #(32) bus ();
  rr_arbiter4_32bit u_dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req = 4'b1111;
    bus.out_ready = 0;
    bus.in1 = data[0];
    bus.in2 = data[1];
    bus.in3 = data[2];
    bus.in4 = data[3];
    tick;
    tick;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_sel", 32'(bus.sel), 0);
    chk("rst_out", bus.out, 0);
    reset = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ack", 32'(bus.ack), 32'(1) << (i % 4));
      tick;
      chk("rr_out", bus.out, data[i % 4]);
      chk("rr_sel", 32'(bus.sel), i % 4);
      chk("rr_valid", 32'(bus.out_valid), 1);
    end
    bus.req = 4'b0000;
    tick;
    chk("drain_valid", 32'(bus.out_valid), 0);
    chk("drain_out", bus.out, data[0]);
    bus.req = 4'b0100;
    bus.out_ready = 0;
    #1;
    chk("one_ack", 32'(bus.ack), 32'b0100);
    tick;
    chk("one_out", bus.out, data[2]);
    chk("one_sel", 32'(bus.sel), 2);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_ack", 32'(bus.ack), 0);
      chk("stall_out", bus.out, data[2]);
      chk("stall_valid", 32'(bus.out_valid), 1);
    end
    bus.out_ready = 1;
    #1;
    chk("reload_ack", 32'(bus.ack), 32'b0100);
    tick;
    chk("reload_out", bus.out, data[2]);
    chk("reload_valid", 32'(bus.out_valid), 1);
    bus.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alt_ack", 32'(bus.ack), 32'(1) << exp_alt[i]);
      tick;
      chk("alt_sel", 32'(bus.sel), 32'(exp_alt[i]));
      chk("alt_out", bus.out, data[exp_alt[i]]);
    end
    bus.req = 4'b1111;
    bus.out_ready = 0;
    reset = 1;
    #1;
    chk("midrst_ack", 32'(bus.ack), 0);
    tick;
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_out", bus.out, 0);
    reset = 0;
    bus.req = 4'b0000;
    tick;
    chk("idle_noreq_valid", 32'(bus.out_valid), 0);
    bus.req = 4'b1111;
    #1;
    chk("postrst_ack", 32'(bus.ack), 32'b0001);
    tick;
    chk("postrst_sel", 32'(bus.sel), 0);
    chk("postrst_out", bus.out, data[0]);
    reset = 1;
    tick;
    reset = 0;
    bus.req = 4'b0011;
    bus.out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("burst_ack", 32'(bus.ack), 32'(1) << exp_b[i]);
      tick;
      chk("burst_sel", 32'(bus.sel), 32'(exp_b[i]));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
